hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_load_use_detect.sv | 31 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared pipeline definitions for the hazard controller: FSM state
//   encoding, flush depth after a taken branch, register-address width
//   and the saturating stall-counter increment.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int FLUSH_DEPTH = 2;
  localparam int FLUSH_CNT_W = 2;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect
//   Purely combinational load-use hazard comparator. Flags when the
//   instruction in execute is a load writing a register that the
//   instruction in decode actually reads.
//   Inputs : id_src1/id_src2 (decode sources), id_uses1/id_uses2 (source
//            valid), ex_mr/ex_rw (execute is load / writes register),
//            ex_reg_dest (execute destination)
//   Output : load_use
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_uses1,
  input  logic                  id_uses2,
  input  logic                  ex_mr,
  input  logic                  ex_rw,
  input  logic [REG_ADDR_W-1:0] ex_reg_dest,
  output logic                  load_use
);

  logic hit1;
  logic hit2;

  always_comb begin
    hit1     = id_uses1 && (id_src1 == ex_reg_dest);
    hit2     = id_uses2 && (id_src2 == ex_reg_dest);
    load_use = ex_mr && ex_rw && (hit1 || hit2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. Stalls on load-use, flushes two slots after
//   a taken branch, and freezes the whole pipe while memory is not ready.
//   Outputs are combinational from the current state and inputs so they are
//   settled before the falling edge where the pipeline buffers latch.
//   Inputs : Clk, Rst (sync, active-high), IdSrc1/IdSrc2, IdUses1/IdUses2,
//            ExMR, ExRW, ExRegDest, BranchTaken, MemWait
//   Outputs: PcStall, FdStall, DeStall, DeBubble, FdFlush, FlashNum[1:0],
//            StallCount[15:0], Busy
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [REG_ADDR_W-1:0]  IdSrc1,
  input  logic [REG_ADDR_W-1:0]  IdSrc2,
  input  logic                   IdUses1,
  input  logic                   IdUses2,
  input  logic                   ExMR,
  input  logic                   ExRW,
  input  logic [REG_ADDR_W-1:0]  ExRegDest,
  input  logic                   BranchTaken,
  input  logic                   MemWait,
  output logic                   PcStall,
  output logic                   FdStall,
  output logic                   DeStall,
  output logic                   DeBubble,
  output logic                   FdFlush,
  output logic [FLUSH_CNT_W-1:0] FlashNum,
  output logic [STALL_CNT_W-1:0] StallCount,
  output logic                   Busy
);

  state_e                 state_q,     state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   load_use;

  logic pc_stall, fd_stall, de_stall, de_bubble, fd_flush;

  load_use_detect u_load_use_detect (
    .id_src1     (IdSrc1),
    .id_src2     (IdSrc2),
    .id_uses1    (IdUses1),
    .id_uses2    (IdUses2),
    .ex_mr       (ExMR),
    .ex_rw       (ExRW),
    .ex_reg_dest (ExRegDest),
    .load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_stall    = 1'b0;
    fd_stall    = 1'b0;
    de_stall    = 1'b0;
    de_bubble   = 1'b0;
    fd_flush    = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Branch wins outright: the flush squashes whatever would have stalled.
        if (BranchTaken) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_CNT_W'(FLUSH_DEPTH);
        end else if (MemWait) begin
          state_d  = ST_HOLD;
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_stall = 1'b1;
        end else if (load_use) begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_bubble = 1'b1;
        end
      end

      ST_FLUSH: begin
        fd_flush  = 1'b1;
        de_bubble = 1'b1;
        // A memory wait freezes the flush countdown along with the pipe.
        if (MemWait) begin
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_stall = 1'b1;
        end else if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_stall = 1'b1;
        if (!MemWait) state_d = ST_RUN;
      end

      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase

    // Reset silences every control output in the cycle it is asserted.
    if (Rst) begin
      pc_stall  = 1'b0;
      fd_stall  = 1'b0;
      de_stall  = 1'b0;
      de_bubble = 1'b0;
      fd_flush  = 1'b0;
    end

    stall_cnt_d = pc_stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    PcStall    = pc_stall;
    FdStall    = fd_stall;
    DeStall    = de_stall;
    DeBubble   = de_bubble;
    FdFlush    = fd_flush;
    FlashNum   = Rst ? '0 : flush_cnt_q;
    StallCount = stall_cnt_q;
    Busy       = !Rst && (state_q != ST_RUN);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Cycle-by-cycle vectors for hazard_ctrl: inputs are driven just after the
//   rising edge, the expected output bundle is queued, and the queue head is
//   compared against the DUT on the following falling edge.
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] IdSrc1 = '0, IdSrc2 = '0, ExRegDest = '0;
  logic       IdUses1 = 1'b0, IdUses2 = 1'b0, ExMR = 1'b0, ExRW = 1'b0;
  logic       BranchTaken = 1'b0, MemWait = 1'b0;
  logic       PcStall, FdStall, DeStall, DeBubble, FdFlush, Busy;
  logic [1:0] FlashNum;
  logic [15:0] StallCount;

  hazard_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .IdSrc1(IdSrc1), .IdSrc2(IdSrc2), .IdUses1(IdUses1), .IdUses2(IdUses2),
    .ExMR(ExMR), .ExRW(ExRW), .ExRegDest(ExRegDest),
    .BranchTaken(BranchTaken), .MemWait(MemWait),
    .PcStall(PcStall), .FdStall(FdStall), .DeStall(DeStall),
    .DeBubble(DeBubble), .FdFlush(FdFlush), .FlashNum(FlashNum),
    .StallCount(StallCount), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rst, br, mw, mr, rw;
    logic [2:0] dest, s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
  } in_t;

  typedef struct packed {
    logic        pc, fd, de, bub, fl;
    logic [1:0]  fnum;
    logic        busy;
    logic [15:0] scnt;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string nm;
  } vec_t;

  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic in_t mk(logic rst, logic br, logic mw, logic mr, logic rw,
                             logic [2:0] dest, logic [2:0] s1, logic u1,
                             logic [2:0] s2, logic u2);
    in_t r;
    r.rst = rst; r.br = br; r.mw = mw; r.mr = mr; r.rw = rw;
    r.dest = dest; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2;
    return r;
  endfunction

  function automatic out_t ex(logic pc, logic fd, logic de, logic bub, logic fl,
                              logic [1:0] fnum, logic busy, logic [15:0] scnt);
    out_t r;
    r.pc = pc; r.fd = fd; r.de = de; r.bub = bub; r.fl = fl;
    r.fnum = fnum; r.busy = busy; r.scnt = scnt;
    return r;
  endfunction

  task automatic check_head();
    out_t  act, e;
    string nm;
    act = '{PcStall, FdStall, DeStall, DeBubble, FdFlush, FlashNum, Busy, StallCount};
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got pc=%b fd=%b de=%b bub=%b fl=%b fnum=%0d busy=%b scnt=%0d, expected pc=%b fd=%b de=%b bub=%b fl=%b fnum=%0d busy=%b scnt=%0d",
               nm, act.pc, act.fd, act.de, act.bub, act.fl, act.fnum, act.busy, act.scnt,
               e.pc, e.fd, e.de, e.bub, e.fl, e.fnum, e.busy, e.scnt);
    end
  endtask

  task automatic cyc(input in_t i, input out_t e, input string nm);
    @(posedge Clk);
    #1;
    Rst = i.rst; BranchTaken = i.br; MemWait = i.mw; ExMR = i.mr; ExRW = i.rw;
    ExRegDest = i.dest; IdSrc1 = i.s1; IdUses1 = i.u1; IdSrc2 = i.s2; IdUses2 = i.u2;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge Clk);
    check_head();
  endtask

  vec_t tbl[18];

  initial begin
    //               rst br mw mr rw dst s1 u1 s2 u2      pc fd de bb fl fn bz sc
    tbl[0]  = '{mk(1, 1, 1, 1, 1, 3, 3, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "reset_state"};
    tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "idle"};
    tbl[2]  = '{mk(0, 0, 0, 1, 1, 3, 3, 1, 0, 0), ex(1, 1, 0, 1, 0, 0, 0, 0), "load_use_src1"};
    tbl[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1), "load_use_one_cycle"};
    tbl[4]  = '{mk(0, 0, 0, 1, 1, 3, 3, 0, 5, 1), ex(0, 0, 0, 0, 0, 0, 0, 1), "no_false_hazard"};
    tbl[5]  = '{mk(0, 0, 0, 1, 1, 3, 0, 0, 3, 1), ex(1, 1, 0, 1, 0, 0, 0, 1), "load_use_src2"};
    tbl[6]  = '{mk(0, 0, 0, 1, 0, 3, 3, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 2), "load_no_regwrite"};
    tbl[7]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 2), "branch_taken"};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 2, 1, 2), "flush_cnt2"};
    tbl[9]  = '{mk(0, 1, 0, 1, 1, 3, 3, 1, 0, 0), ex(0, 0, 0, 1, 1, 1, 1, 2), "flush_cnt1_ignores"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 2), "flush_done"};
    tbl[11] = '{mk(0, 1, 1, 1, 1, 3, 3, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 2), "simultaneous"};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 2, 1, 2), "simul_flush_cnt2"};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 1, 1, 2), "simul_flush_cnt1"};
    tbl[14] = '{mk(0, 0, 1, 1, 1, 3, 3, 1, 0, 0), ex(1, 1, 1, 0, 0, 0, 0, 2), "wait_over_load_use"};
    tbl[15] = '{mk(0, 1, 1, 1, 1, 3, 3, 1, 0, 0), ex(1, 1, 1, 0, 0, 0, 1, 3), "hold_ignores"};
    tbl[16] = '{mk(0, 0, 0, 1, 1, 3, 3, 1, 0, 0), ex(1, 1, 1, 0, 0, 0, 1, 4), "hold_release"};
    tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 5), "after_hold"};

    repeat (2) @(posedge Clk);

    for (int k = 0; k < 18; k++) cyc(tbl[k].i, tbl[k].o, tbl[k].nm);

    // Wait inside a flush: countdown frozen at 2 for three cycles.
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 5), "wif_reset");
    cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "wif_branch");
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 1, 1, 1, 2, 1, 0), "wif_wait1");
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 1, 1, 1, 2, 1, 1), "wif_wait2");
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 1, 1, 1, 2, 1, 2), "wif_wait3");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 2, 1, 3), "wif_resume_cnt2");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 1, 1, 1, 3), "wif_cnt1");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 3), "wif_done");

    // Reset in the middle of HOLD.
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0, 3), "rh_enter_hold");
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 1, 4), "rh_in_hold");
    cyc(mk(1, 0, 1, 1, 1, 3, 3, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 5), "rh_reset_asserted");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "rh_after_reset");

    // Reset in the middle of FLUSH.
    cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "rf_branch");
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "rf_reset_asserted");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "rf_after_reset");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), "rf_stays_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
